mem_bus_arbiter: RTL and testbench

- Shares one external memory bus between instruction fetch (read-only) and the mem_branch stage (read/write).
- Registered request/acknowledge handshake toward both requesters; variable-latency handshake toward the bus.
- The pipeline stalls on a pending requester while its ack is low.
- Data accesses have priority (older instruction), bounded by an anti-starvation limit for fetch; a bus timeout reports errors for trap generation.

---
 rtl/mem_bus_arbiter_if.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the two requesters (fetch, mem_branch), the arbiter and the external memory bus.
// Handshake: a requester raises *_req with stable fields and holds them until its one-cycle *_ack;
// bus_req stays high with stable fields until a one-cycle bus_ack or the arbiter's timeout drops it.
interface mem_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        mb_req;
  logic        mb_we;
  logic [31:0] mb_addr;
  logic [31:0] mb_wdata;
  logic [3:0]  mb_wstrb;
  logic        mb_ack;
  logic [31:0] mb_rdata;
  logic        mb_err;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic        busy;
  logic [1:0]  state_dbg;

  modport slave (
    input  if_req, if_addr, mb_req, mb_we, mb_addr, mb_wdata, mb_wstrb, bus_ack, bus_rdata,
    output if_ack, if_rdata, if_err, mb_ack, mb_rdata, mb_err,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, busy, state_dbg
  );

  modport master (
    output if_req, if_addr, mb_req, mb_we, mb_addr, mb_wdata, mb_wstrb, bus_ack, bus_rdata,
    input  if_ack, if_rdata, if_err, mb_ack, mb_rdata, mb_err,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, busy, state_dbg
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: data accesses win ties, fetch is forced in after a bounded
// data streak, and a stalled bus transfer is aborted with an error after TIMEOUT cycles.
module mem_bus_arbiter #(
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 255
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.slave  a
);
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} state_e;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_BURST);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  timer_q, timer_d;
  logic        gnt_mb_q, gnt_mb_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic        if_ack_q, if_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_err_q, if_err_d;
  logic        mb_ack_q, mb_ack_d;
  logic [31:0] mb_rdata_q, mb_rdata_d;
  logic        mb_err_q, mb_err_d;
  logic        busy_q, busy_d;

  // Fetch addresses are word aligned; the low bits never reach the bus.
  logic if_addr_lsb_unused;
  assign if_addr_lsb_unused = ^a.if_addr[1:0];

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    timer_d     = timer_q;
    gnt_mb_d    = gnt_mb_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    if_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    mb_ack_d    = 1'b0;
    mb_rdata_d  = mb_rdata_q;
    mb_err_d    = mb_err_q;

    case (state_q)
      IDLE: begin
        if (a.mb_req && (!a.if_req || (streak_q < MAX_STREAK))) begin
          gnt_mb_d    = 1'b1;
          streak_d    = a.if_req ? (streak_q + 4'd1) : 4'd0;
          bus_we_d    = a.mb_we;
          bus_addr_d  = a.mb_addr;
          bus_wdata_d = a.mb_wdata;
          bus_wstrb_d = a.mb_we ? a.mb_wstrb : 4'd0;
          bus_req_d   = 1'b1;
          timer_d     = 8'd0;
          state_d     = XFER;
        end else if (a.if_req) begin
          gnt_mb_d    = 1'b0;
          streak_d    = 4'd0;
          bus_we_d    = 1'b0;
          bus_addr_d  = {a.if_addr[31:2], 2'b00};
          bus_wdata_d = 32'd0;
          bus_wstrb_d = 4'd0;
          bus_req_d   = 1'b1;
          timer_d     = 8'd0;
          state_d     = XFER;
        end
      end
      XFER: begin
        // An ack landing on the last timer count still counts as a clean completion.
        if (a.bus_ack || (timer_q == TIMER_LAST)) begin
          bus_req_d = 1'b0;
          state_d   = RESP;
          if (gnt_mb_q) begin
            mb_ack_d   = 1'b1;
            mb_rdata_d = a.bus_ack ? a.bus_rdata : 32'd0;
            mb_err_d   = !a.bus_ack;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = a.bus_ack ? a.bus_rdata : 32'd0;
            if_err_d   = !a.bus_ack;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      timer_q     <= 8'd0;
      gnt_mb_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_wstrb_q <= 4'd0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      if_err_q    <= 1'b0;
      mb_ack_q    <= 1'b0;
      mb_rdata_q  <= 32'd0;
      mb_err_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      timer_q     <= timer_d;
      gnt_mb_q    <= gnt_mb_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      if_ack_q    <= if_ack_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      mb_ack_q    <= mb_ack_d;
      mb_rdata_q  <= mb_rdata_d;
      mb_err_q    <= mb_err_d;
      busy_q      <= busy_d;
    end
  end

  assign a.bus_req   = bus_req_q;
  assign a.bus_we    = bus_we_q;
  assign a.bus_addr  = bus_addr_q;
  assign a.bus_wdata = bus_wdata_q;
  assign a.bus_wstrb = bus_wstrb_q;
  assign a.if_ack    = if_ack_q;
  assign a.if_rdata  = if_rdata_q;
  assign a.if_err    = if_err_q;
  assign a.mb_ack    = mb_ack_q;
  assign a.mb_rdata  = mb_rdata_q;
  assign a.mb_err    = mb_err_q;
  assign a.busy      = busy_q;
  assign a.state_dbg = state_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised bench for mem_bus_arbiter: a transaction-level model schedules grants and bus
// responses, pushes expected bus transfers and requester responses, and a monitor checks them.
module tb_mem_bus_arbiter;
  localparam int MAXB  = 2;
  localparam int TMO   = 8;
  localparam int N_GEN = 2600;
  localparam int N_ALL = N_GEN + 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_bus_arbiter_if a();

  mem_bus_arbiter #(.MAX_DATA_BURST(MAXB), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  // {len[7:0], we, addr[31:0], wdata[31:0], wstrb[3:0]}
  logic [76:0] exp_bus_q[$];
  // {port_is_mb, err, rdata[31:0]}
  logic [33:0] exp_resp_q[$];
  logic        exp_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops expectations whenever the DUT presents them.
  initial begin
    logic [76:0] cur_bus;
    logic [33:0] r;
    logic        mon_in;
    logic        mon_unstable;
    int          mon_len;
    mon_in = 1'b0;
    mon_unstable = 1'b0;
    mon_len = 0;
    cur_bus = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_in = 1'b0;
      end else begin
        check("busy", 32'(a.busy), 32'(exp_busy));
        if (a.bus_req) begin
          if (!mon_in) begin
            mon_in = 1'b1;
            mon_len = 1;
            mon_unstable = 1'b0;
            if (exp_bus_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL bus_grant: unexpected transfer addr %h, expected none", a.bus_addr);
              cur_bus = {8'd0, a.bus_we, a.bus_addr, a.bus_wdata, a.bus_wstrb};
            end else begin
              cur_bus = exp_bus_q.pop_front();
              check("bus_we",    32'(a.bus_we),    32'(cur_bus[68]));
              check("bus_addr",  a.bus_addr,       cur_bus[67:36]);
              check("bus_wdata", a.bus_wdata,      cur_bus[35:4]);
              check("bus_wstrb", 32'(a.bus_wstrb), 32'(cur_bus[3:0]));
            end
          end else begin
            mon_len++;
            if ({a.bus_we, a.bus_addr, a.bus_wdata, a.bus_wstrb} !== cur_bus[68:0])
              mon_unstable = 1'b1;
          end
        end else if (mon_in) begin
          mon_in = 1'b0;
          check("bus_req_len", 32'(mon_len), 32'(cur_bus[76:69]));
          check("bus_stable", 32'(mon_unstable), 32'd0);
        end
        if (a.if_ack || a.mb_ack) begin
          if (a.if_ack && a.mb_ack) begin
            n_vec++;
            n_err++;
            $display("FAIL dual_ack: got if_ack=1 mb_ack=1, expected one");
          end
          if (exp_resp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_unexpected: got if_ack=%b mb_ack=%b, expected none", a.if_ack, a.mb_ack);
          end else begin
            r = exp_resp_q.pop_front();
            check("ack_port", 32'(a.mb_ack), 32'(r[33]));
            check("ack_err",  32'(a.mb_ack ? a.mb_err : a.if_err), 32'(r[32]));
            check("ack_rdata", a.mb_ack ? a.mb_rdata : a.if_rdata, r[31:0]);
          end
        end
      end
    end
  end

  // Stimulus and reference model. Cycle bookkeeping is per rising edge index e.
  initial begin
    bit          if_pend, mb_pend, inflight, win_mb, tmo, did_rst, rst_release;
    logic [31:0] if_addr_v, mb_addr_v, mb_wdata_v, ack_rdata;
    logic        mb_we_v;
    logic [3:0]  mb_wstrb_v;
    int          next_arb, grant_edge, resp_edge, ack_edge, last_resp, streak, d, lat, p_req, sel;

    if_pend = 0; mb_pend = 0; inflight = 0; win_mb = 0; tmo = 0; did_rst = 0; rst_release = 0;
    if_addr_v = 0; mb_addr_v = 0; mb_wdata_v = 0; ack_rdata = 0; mb_we_v = 0; mb_wstrb_v = 0;
    grant_edge = -10; resp_edge = -10; ack_edge = -10; last_resp = -10; streak = 0; d = 0; lat = 0;
    next_arb = 1;

    a.if_req = 0; a.if_addr = 0; a.mb_req = 0; a.mb_we = 0; a.mb_addr = 0;
    a.mb_wdata = 0; a.mb_wstrb = 0; a.bus_ack = 0; a.bus_rdata = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_req",   32'(a.bus_req),   32'd0);
    check("rst_bus_we",    32'(a.bus_we),    32'd0);
    check("rst_bus_addr",  a.bus_addr,       32'd0);
    check("rst_bus_wdata", a.bus_wdata,      32'd0);
    check("rst_bus_wstrb", 32'(a.bus_wstrb), 32'd0);
    check("rst_if_ack",    32'(a.if_ack),    32'd0);
    check("rst_mb_ack",    32'(a.mb_ack),    32'd0);
    check("rst_if_err",    32'(a.if_err),    32'd0);
    check("rst_mb_err",    32'(a.mb_err),    32'd0);
    check("rst_if_rdata",  a.if_rdata,       32'd0);
    check("rst_mb_rdata",  a.mb_rdata,       32'd0);
    check("rst_busy",      32'(a.busy),      32'd0);
    rst = 1'b0;

    for (int e = 1; e <= N_ALL; e++) begin
      @(posedge clk);
      #1;
      if (rst_release) begin
        rst = 1'b0;
        rst_release = 0;
      end

      // What the arbiter did at edge e, from the rules on pending requests.
      if (inflight && e == resp_edge) begin
        inflight = 0;
        last_resp = e;
        if (win_mb) mb_pend = 0;
        else        if_pend = 0;
      end else if (!inflight && e >= next_arb) begin
        if (mb_pend || if_pend) begin
          if (mb_pend && (!if_pend || streak < MAXB)) begin
            win_mb = 1;
            streak = if_pend ? streak + 1 : 0;
          end else begin
            win_mb = 0;
            streak = 0;
          end
          sel = $urandom_range(0, 9);
          if (sel < 6)       d = $urandom_range(0, 3);
          else if (sel < 8)  d = $urandom_range(0, TMO - 1);
          else if (sel == 8) d = TMO - 1;
          else               d = $urandom_range(TMO, TMO + 1);
          tmo = (d >= TMO);
          lat = tmo ? TMO - 1 : d;
          grant_edge = e;
          ack_edge = e + 1 + d;
          resp_edge = e + 1 + lat;
          next_arb = e + 3 + lat;
          ack_rdata = $urandom;
          inflight = 1;
          if (win_mb)
            exp_bus_q.push_back({8'(lat + 1), mb_we_v, mb_addr_v, mb_wdata_v,
                                 mb_we_v ? mb_wstrb_v : 4'h0});
          else
            exp_bus_q.push_back({8'(lat + 1), 1'b0, if_addr_v & 32'hFFFF_FFFC, 32'h0, 4'h0});
          exp_resp_q.push_back({win_mb, tmo, tmo ? 32'h0 : ack_rdata});
          // The winner keeps req high but its fields may now wander.
          if (win_mb) begin
            mb_addr_v = $urandom; mb_wdata_v = $urandom; mb_wstrb_v = 4'($urandom_range(0, 15));
          end else begin
            if_addr_v = $urandom & 32'hFFFF_FFFC;
          end
        end else begin
          next_arb = e + 1;
        end
      end
      exp_busy = inflight || (e == last_resp);

      // Reset in the middle of a transfer: bus_req must drop at once and nothing completes.
      if (!did_rst && e > 1200 && inflight && e > grant_edge && e < resp_edge) begin
        #2;
        rst = 1'b1;
        #1;
        check("midrst_bus_req", 32'(a.bus_req), 32'd0);
        check("midrst_busy",    32'(a.busy),    32'd0);
        check("midrst_acks",    32'({a.if_ack, a.mb_ack}), 32'd0);
        inflight = 0;
        exp_resp_q.delete();
        streak = 0;
        next_arb = e + 2;
        ack_edge = -10;
        last_resp = -10;
        exp_busy = 1'b0;
        did_rst = 1;
        rst_release = 1;
      end

      // Drive inputs for edge e+1.
      p_req = (e < 1000) ? 50 : (e < 1800) ? 100 : (e < N_GEN) ? 30 : 0;
      if (!if_pend && $urandom_range(0, 99) < p_req) begin
        if_pend = 1;
        if_addr_v = $urandom & 32'hFFFF_FFFC;
      end
      if (!mb_pend && $urandom_range(0, 99) < p_req) begin
        mb_pend = 1;
        mb_we_v = 1'($urandom_range(0, 1));
        mb_addr_v = $urandom;
        mb_wdata_v = $urandom;
        mb_wstrb_v = 4'($urandom_range(0, 15));
      end
      a.if_req   = if_pend;
      a.if_addr  = if_pend ? if_addr_v : $urandom;
      a.mb_req   = mb_pend;
      a.mb_we    = mb_pend ? mb_we_v : 1'($urandom_range(0, 1));
      a.mb_addr  = mb_pend ? mb_addr_v : $urandom;
      a.mb_wdata = mb_pend ? mb_wdata_v : $urandom;
      a.mb_wstrb = mb_pend ? mb_wstrb_v : 4'($urandom_range(0, 15));
      a.bus_ack  = (e + 1 == ack_edge) || (!inflight && $urandom_range(0, 7) == 0);
      a.bus_rdata = (e + 1 == ack_edge) ? ack_rdata : $urandom;
    end

    @(posedge clk);
    #1;
    check("exp_bus_left",  32'(exp_bus_q.size()),  32'd0);
    check("exp_resp_left", 32'(exp_resp_q.size()), 32'd0);
    check("mid_reset_hit", 32'(did_rst), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
